// File: rtl/processor_pkg.sv
// processor_pkg: shared constants and types for the execute-stage units.
// Holds ALU opcodes, multdiv FSM states, default width and INT_MIN.
package processor_pkg;

  localparam int WIDTH_DEF = 32;

  localparam logic [4:0] OP_MUL = 5'b00110;
  localparam logic [4:0] OP_DIV = 5'b00111;

  localparam logic [31:0] INT_MIN = 32'h8000_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } md_state_e;

endpackage

// File: rtl/multdiv_unit_if.sv
// multdiv_unit_if: execute stage <-> multdiv unit bundle.
// master = execute stage (operands, start pulses); slave = the unit.
interface multdiv_unit_if #(
  parameter int WIDTH = 32
);

  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic             ctrl_MULT;
  logic             ctrl_DIV;
  logic [WIDTH-1:0] data_result;
  logic             data_exception;
  logic             data_resultRDY;
  logic             busy;

  modport master (
    output data_operandA,
    output data_operandB,
    output ctrl_MULT,
    output ctrl_DIV,
    input  data_result,
    input  data_exception,
    input  data_resultRDY,
    input  busy
  );

  modport slave (
    input  data_operandA,
    input  data_operandB,
    input  ctrl_MULT,
    input  ctrl_DIV,
    output data_result,
    output data_exception,
    output data_resultRDY,
    output busy
  );

endinterface

// File: rtl/multdiv_counter.sv
// multdiv_counter: iteration counter for multicycle units.
// Ports: clock, reset (async high), clr (sync), en, last (cnt == WIDTH-1).
module multdiv_counter #(
  parameter int CNT_W = 6,
  parameter int WIDTH = 32
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic last
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign last = (cnt == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/multdiv_unit.sv
// multdiv_unit: iterative signed Booth multiply / non-restoring divide.
// Ports: clock, reset (async high), md (multdiv_unit_if.slave).
// Option: MULTDIV_DIVZERO_FAST_EN finishes divide-by-zero right away.
module multdiv_unit
  import processor_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = 6
) (
  input  logic clock,
  input  logic reset,
  multdiv_unit_if.slave md
);

  localparam int PW = 2 * WIDTH + 1;
  localparam logic [WIDTH-1:0] MIN_V = {1'b1, {(WIDTH-1){1'b0}}};

  md_state_e        state;
  logic [PW-1:0]    prod;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] dvsr;
  logic [WIDTH-1:0] quo;
  logic [WIDTH+1:0] rem;
  logic             neg_q;
  logic             div_zero;
  logic             div_ovf;
  logic             last;
  logic             cnt_en;

  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   b_add;
  logic [WIDTH:0]   b_sum;
  logic [PW-1:0]    prod_nx;
  logic             mul_exc;
  logic [WIDTH+1:0] r_sh;
  logic [WIDTH+1:0] r_nx;
  logic [WIDTH-1:0] q_nx;
  logic [WIDTH-1:0] q_res;

  assign cnt_en = (state == ST_MUL) || (state == ST_DIV);

  multdiv_counter #(
    .CNT_W (CNT_W),
    .WIDTH (WIDTH)
  ) u_cnt (
    .clock (clock),
    .reset (reset),
    .clr   (md.ctrl_MULT | md.ctrl_DIV),
    .en    (cnt_en),
    .last  (last)
  );

  assign a_mag = md.data_operandA[WIDTH-1] ?
                 -md.data_operandA : md.data_operandA;
  assign b_mag = md.data_operandB[WIDTH-1] ?
                 -md.data_operandB : md.data_operandB;

  // Booth step: add in WIDTH+1 bits so -INT_MIN does not wrap,
  // then arithmetic shift right of the whole product register.
  always_comb begin
    b_add = '0;
    case (prod[1:0])
      2'b01:   b_add = {mcand[WIDTH-1], mcand};
      2'b10:   b_add = -{mcand[WIDTH-1], mcand};
      default: b_add = '0;
    endcase
    b_sum   = {prod[PW-1], prod[PW-1:WIDTH+1]} + b_add;
    prod_nx = {b_sum, prod[WIDTH:1]};
  end

  // Product fits iff its top WIDTH+1 bits are a pure sign extension.
  assign mul_exc = !((&prod_nx[PW-1:WIDTH]) || !(|prod_nx[PW-1:WIDTH]));

  // Non-restoring step: dividend shifts out of quo into rem.
  always_comb begin
    r_sh  = {rem[WIDTH:0], quo[WIDTH-1]};
    r_nx  = rem[WIDTH+1] ? r_sh + {2'b00, dvsr} : r_sh - {2'b00, dvsr};
    q_nx  = {quo[WIDTH-2:0], ~r_nx[WIDTH+1]};
    q_res = neg_q ? -q_nx : q_nx;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state             <= ST_IDLE;
      prod              <= '0;
      mcand             <= '0;
      dvsr              <= '0;
      quo               <= '0;
      rem               <= '0;
      neg_q             <= 1'b0;
      div_zero          <= 1'b0;
      div_ovf           <= 1'b0;
      md.data_result    <= '0;
      md.data_exception <= 1'b0;
      md.data_resultRDY <= 1'b0;
      md.busy           <= 1'b0;
    end else begin
      md.data_resultRDY <= 1'b0;
      if (md.ctrl_MULT) begin
        state   <= ST_MUL;
        prod    <= {{WIDTH{1'b0}}, md.data_operandB, 1'b0};
        mcand   <= md.data_operandA;
        md.busy <= 1'b1;
      end else if (md.ctrl_DIV) begin
        dvsr     <= b_mag;
        quo      <= a_mag;
        rem      <= '0;
        neg_q    <= md.data_operandA[WIDTH-1] ^ md.data_operandB[WIDTH-1];
        div_zero <= (md.data_operandB == '0);
        div_ovf  <= (md.data_operandA == MIN_V) && (&md.data_operandB);
        md.busy  <= 1'b1;
`ifdef MULTDIV_DIVZERO_FAST_EN
        if (md.data_operandB == '0) begin
          state             <= ST_DONE;
          md.data_result    <= '0;
          md.data_exception <= 1'b1;
          md.data_resultRDY <= 1'b1;
        end else begin
          state <= ST_DIV;
        end
`else
        state <= ST_DIV;
`endif
      end else begin
        case (state)
          ST_MUL: begin
            prod <= prod_nx;
            if (last) begin
              state             <= ST_DONE;
              md.data_result    <= prod_nx[WIDTH:1];
              md.data_exception <= mul_exc;
              md.data_resultRDY <= 1'b1;
            end
          end
          ST_DIV: begin
            rem <= r_nx;
            quo <= q_nx;
            if (last) begin
              state             <= ST_DONE;
              md.data_result    <= div_zero ? '0 :
                                   div_ovf  ? MIN_V : q_res;
              md.data_exception <= div_zero | div_ovf;
              md.data_resultRDY <= 1'b1;
            end
          end
          ST_DONE: begin
            state   <= ST_IDLE;
            md.busy <= 1'b0;
          end
          default: begin
            state   <= ST_IDLE;
            md.busy <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/multdiv_unit.md
Name: multdiv_unit

Overview:
- Iterative 32-bit signed multiply/divide unit in the execute stage, beside the ALU.
- The execute stage pulses a start and stalls the FD/DX latches until the result is ready.
- The result and exception flag feed the XM latch, which raises the overflow/exception writeback path to $rstatus.
- Handles the mul and div ALU opcodes (00110, 00111) of R-type instructions.

Parameters:
- WIDTH, 32, operand/result width in bits.
- CNT_W, 6, iteration counter width; must hold the value WIDTH.

Ports:
- clock  input  1  master clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- data_operandA  input  WIDTH  multiplicand / dividend, signed two's complement.
- data_operandB  input  WIDTH  multiplier / divisor, signed two's complement.
- ctrl_MULT  input  1  one-cycle start pulse for multiply.
- ctrl_DIV  input  1  one-cycle start pulse for divide.
- data_result  output  WIDTH  low WIDTH bits of product, or quotient.
- data_exception  output  1  overflow or divide-by-zero flag.
- data_resultRDY  output  1  one-cycle pulse; result valid.
- busy  output  1  high while an operation is in flight (stall request).

Behaviour:
- Clock and reset: single clock domain `clock`. `reset` is asynchronous and active-high.
- Reset values: state IDLE; counter 0; data_result 0; data_exception 0; data_resultRDY 0; busy 0.
- State machine: IDLE, MUL, DIV, DONE.
- Operand capture: on any edge where ctrl_MULT or ctrl_DIV is high, operands are captured into internal registers, the counter is cleared, and the state goes to MUL or DIV. This applies from any state.
- Simultaneous starts: if ctrl_MULT and ctrl_DIV are both high, MULT wins.
- Start while busy: aborts the current operation and restarts with the new operands. No RDY is issued for the aborted operation.
- MUL: radix-2 Booth, one step per cycle, over a 2*WIDTH+1-bit product register. After WIDTH steps the state goes to DONE.
- DIV: non-restoring division on the operand magnitudes, one step per cycle. After WIDTH steps the state goes to DONE. The quotient is negated when the operand signs differ, giving truncation toward zero. The remainder is discarded.
- DONE:
  - data_result and data_exception register the final values.
  - data_resultRDY is high for exactly this one cycle.
  - Next state is IDLE, unless a new start arrives on the same edge, in which case the start is taken.
- Latency: RDY is high in the cycle after the 33rd rising edge counted from the sampling edge (WIDTH+1 edges).
- busy: high from the edge after a start until the DONE cycle inclusive.
- Output hold: data_result and data_exception hold their values after RDY until the next DONE or reset.
- Multiply exception: set when the full product's upper WIDTH+1 bits are not all equal, i.e. the product does not fit in a signed 32-bit value.
- Divide exceptions:
  - divisor 0: result 0, exception 1.
  - 0x80000000 / -1: result 0x80000000, exception 1.
  - All other divides: exception 0.
- Reset mid-operation: immediate return to IDLE with all outputs 0, and no RDY.

Optional Feature:
- MULTDIV_DIVZERO_FAST_EN
  - Defined: a DIV start with operandB == 0 goes directly to DONE. RDY pulses on the cycle after the sampling edge, with result 0 and exception 1.
  - Undefined: divide-by-zero runs the full WIDTH iterations and reports at normal latency. Result and exception values are identical in both builds.

Decomposition:
- Shared package (processor_pkg):
  - ALU opcode constants OP_MUL = 5'b00110 and OP_DIV = 5'b00111.
  - State encodings for IDLE, MUL, DIV, DONE.
  - WIDTH default.
  - INT_MIN constant 32'h80000000.
- One natural sub-module: multdiv_counter, a CNT_W-bit counter with synchronous clear and async reset that asserts `last` at WIDTH-1. It is reusable by future multicycle units.

Test Plan:
- MULT, A=7, B=-3 -> RDY pulse exactly 33 edges later; result 0xFFFFFFEB; exception 0; busy high for 33 cycles.
- MULT, A=0x00010000, B=0x00010000 -> result 0x00000000, exception 1. MULT, A=-1, B=-1 -> result 1, exception 0.
- DIV, A=-100, B=7 -> result 0xFFFFFFF2 (-14), exception 0. DIV, A=0x80000000, B=-1 -> result 0x80000000, exception 1.
- DIV, A=5, B=0 -> result 0, exception 1. RDY at 33 edges with the macro undefined, 1 edge with it defined.
- MULT, A=3, B=4, then DIV, A=20, B=4 pulsed 10 cycles later -> no RDY for the multiply; a single RDY 33 edges after the DIV start with result 5.
- MULT started, reset asserted asynchronously mid-cycle at cycle 15 -> outputs 0 immediately, busy 0, and no RDY afterwards until a new start.
